// File: rtl/inv_linear.sv
// inv_linear - Kuznyechik (GOST R 34.12-2015) inverse linear transform L^-1.
//
// Takes one 128-bit block over a valid/ready handshake and applies R^-1 sixteen times,
// STEPS_PER_CYCLE steps per busy clock. The result is returned over a valid/ready handshake.
// In the decoder round this block sits between key addition X[K] and the inverse S-box.
//
// Optional feature macro: INV_LINEAR_KEYADD_EN
//   When defined, adds key_i. The accept edge then loads data_i ^ key_i, fusing X[K] ahead
//   of L^-1. When undefined, data_i is loaded unmodified. Timing is identical in both builds.
//
// Parameters
//   STEPS_PER_CYCLE  R^-1 steps per busy clock: 1, 2, 4, 8 or 16 (busy clocks = 16/STEPS)
//
// Ports
//   clk      in   1    clock, rising edge
//   rst      in   1    asynchronous reset, active low
//   valid_i  in   1    data_i valid
//   ready_o  out  1    high in IDLE only (decoded from state)
//   data_i   in   128  input block, byte a15 = [127:120] ... a0 = [7:0]
//   key_i    in   128  round key (INV_LINEAR_KEYADD_EN builds only)
//   valid_o  out  1    data_o holds a finished result
//   ready_i  in   1    downstream accepts data_o
//   data_o   out  128  result, same byte order as data_i

module inv_linear #(
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] data_i,
`ifdef INV_LINEAR_KEYADD_EN
  input  logic [127:0] key_i,
`endif
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] data_o
);

  // Elaboration-time legality check.
  if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4 ||
        STEPS_PER_CYCLE == 8 || STEPS_PER_CYCLE == 16)) begin : g_bad_steps
    $error("inv_linear: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Coefficients of l(): byte [8*i +: 8] multiplies x_i (x15 in the top byte).
  localparam logic [127:0] LCoef = 128'h94_20_85_10_C2_C0_01_FB_01_C0_C2_10_85_20_94_01;

  localparam logic [4:0] StepInc = 5'(STEPS_PER_CYCLE);

  // Multiply by x in GF(2^8) modulo x^8+x^7+x^6+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'hC3 : 8'h00);
  endfunction

  // Shift-and-add multiply; with b constant this folds to a small XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] prod;
    logic [7:0] acc_a;
    prod  = 8'h00;
    acc_a = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ acc_a;
      acc_a = gf_xtime(acc_a);
    end
    return prod;
  endfunction

  // l(x15..x0), x15 in the top byte.
  function automatic logic [7:0] lin_l(input logic [127:0] x);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 16; i++) begin
      acc = acc ^ gf_mul(x[8*i +: 8], LCoef[8*i +: 8]);
    end
    return acc;
  endfunction

  // R^-1(a15..a0) = {a14..a0, l(a14..a0, a15)}
  function automatic logic [127:0] r_inv(input logic [127:0] a);
    return {a[119:0], lin_l({a[119:0], a[127:120]})};
  endfunction

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e         state_q, state_d;
  logic [127:0]   blk_q, blk_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   load_val;
  logic [4:0]     cnt_sum;
  logic           last_step;

  // Combinational chain of STEPS_PER_CYCLE rounds of R^-1 on the working block.
  logic [127:0] chain [STEPS_PER_CYCLE+1];

  assign chain[0] = blk_q;
  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_chain
    assign chain[g+1] = r_inv(chain[g]);
  end

`ifdef INV_LINEAR_KEYADD_EN
  assign load_val = data_i ^ key_i;
`else
  assign load_val = data_i;
`endif

  // The counter steps in multiples of STEPS_PER_CYCLE, so the sum reaches exactly 16 on the
  // final busy clock; bit 4 flags completion and the low bits wrap the counter to 0.
  assign cnt_sum   = {1'b0, cnt_q} + StepInc;
  assign last_step = cnt_sum[4];

  assign ready_o = (state_q == StIdle);
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          blk_d   = load_val;
          cnt_d   = 4'd0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        blk_d = chain[STEPS_PER_CYCLE];
        cnt_d = cnt_sum[3:0];
        if (last_step) begin
          state_d = StDone;
          valid_d = 1'b1;
          data_d  = chain[STEPS_PER_CYCLE];
        end
      end
      StDone: begin
        // valid_i is ignored here; a new block is only taken from IDLE.
        if (ready_i) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      blk_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_inv_linear.sv
// tb_inv_linear - self-checking bench for inv_linear.
// Five DUT copies (STEPS_PER_CYCLE = 1, 2, 4, 8, 16) with independent handshakes are checked
// against a byte-queue reference model of L^-1. Latency is counted in rising edges from the
// accept edge (inclusive) up to the edge that raises valid_o (inclusive).

module tb_inv_linear;

  localparam int NDut = 5;
  localparam logic [127:0] StdIn  = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
  localparam logic [127:0] StdOut = 128'h64a59400000000000000000000000000;

  logic         clk;
  logic         rst;
  logic         vld   [NDut];
  logic         rdy   [NDut];
  logic [127:0] din   [NDut];
  logic [127:0] key_s [NDut];
  logic         vout  [NDut];
  logic         rdy_i [NDut];
  logic [127:0] dout  [NDut];

  int n_checks;
  int n_fail;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    inv_linear #(
      .STEPS_PER_CYCLE(32'd1 << g)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (vld[g]),
      .ready_o (rdy[g]),
      .data_i  (din[g]),
`ifdef INV_LINEAR_KEYADD_EN
      .key_i   (key_s[g]),
`endif
      .valid_o (vout[g]),
      .ready_i (rdy_i[g]),
      .data_o  (dout[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Carry-less product, then long division by 0x1C3.
  function automatic logic [7:0] ref_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h01C3 << (i - 8));
    return p[7:0];
  endfunction

  // n applications of R^-1 on a byte queue, q[0] = a15.
  function automatic logic [127:0] ref_rinv_n(input logic [127:0] a, input int n);
    logic [7:0]   q[$];
    logic [7:0]   coef [16];
    logic [7:0]   t;
    logic [7:0]   acc;
    logic [127:0] r;
    coef = '{8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
             8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};
    for (int i = 15; i >= 0; i--) q.push_back(a[8*i +: 8]);
    for (int s = 0; s < n; s++) begin
      t = q.pop_front();
      q.push_back(t);               // sequence is now a14..a0, a15
      acc = 8'h00;
      for (int j = 0; j < 16; j++) acc = acc ^ ref_gf_mul(q[j], coef[j]);
      q[15] = acc;
    end
    r = '0;
    for (int j = 0; j < 16; j++) r[8*(15-j) +: 8] = q[j];
    return r;
  endfunction

  function automatic logic [127:0] key_eff(input logic [127:0] k);
`ifdef INV_LINEAR_KEYADD_EN
    return k;
`else
    return k & 128'h0;
`endif
  endfunction

  // Send one block to DUT u; hold ready_i low for 'hold' clocks once valid_o rises.
  task automatic send(input int u, input logic [127:0] d, input logic [127:0] k, input int hold,
                      output logic [127:0] res, output logic [127:0] exp, output int lat);
    int waits;
    res = '0;
    lat = 0;
    waits = 0;
    @(negedge clk);
    rdy_i[u] = (hold == 0);
    while (!rdy[u] && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!rdy[u]) begin
      check_eq("ready_timeout", 128'(rdy[u]), 128'd1);
      exp = '0;
      return;
    end
    vld[u]   = 1'b1;
    din[u]   = d;
    key_s[u] = k;
    exp = ref_rinv_n(din[u] ^ key_eff(key_s[u]), 16);
    @(posedge clk);                 // accept edge
    lat = 1;
    @(negedge clk);
    vld[u]   = 1'b0;
    din[u]   = {$urandom, $urandom, $urandom, $urandom};
    key_s[u] = {$urandom, $urandom, $urandom, $urandom};
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (vout[u]) break;
    end
    if (!vout[u]) begin
      check_eq("valid_timeout", 128'(vout[u]), 128'd1);
      rdy_i[u] = 1'b1;
      return;
    end
    res = dout[u];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      vld[u] = 1'($urandom_range(0, 1));
      din[u] = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      check_eq("bp_valid", 128'(vout[u]), 128'd1);
      check_eq("bp_data", dout[u], res);
      check_eq("bp_ready", 128'(rdy[u]), 128'd0);
    end
    @(negedge clk);
    vld[u]   = 1'b0;
    rdy_i[u] = 1'b1;
    @(posedge clk);
    #1;
    check_eq("handoff_valid", 128'(vout[u]), 128'd0);
    check_eq("handoff_ready", 128'(rdy[u]), 128'd1);
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] exp;
    int           lat;
    int           u;
    int           hold;
    bit           stale;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    for (int i = 0; i < NDut; i++) begin
      vld[i]   = 1'b0;
      din[i]   = '0;
      key_s[i] = '0;
      rdy_i[i] = 1'b1;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDut; i += 4) begin
      check_eq("rst_ready", 128'(rdy[i]), 128'd1);
      check_eq("rst_valid", 128'(vout[i]), 128'd0);
      check_eq("rst_data", dout[i], 128'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", 128'(rdy[0]), 128'd1);

    // Model single-step sanity
    check_eq("model_step", ref_rinv_n(128'h94000000000000000000000000000001, 1),
             128'h00000000000000000000000000000100);

    // Standard vector across the parameter sweep
    for (int i = 0; i < NDut; i++) begin
      send(i, StdIn, '0, 0, res, exp, lat);
      check_eq("std_vector", res, StdOut);
      check_eq("std_model", exp, StdOut);
      check_eq("std_latency", 128'(lat), 128'(16 / (1 << i) + 1));
    end

    // Backpressure, then an immediate follow-on block
    send(0, StdIn, '0, 10, res, exp, lat);
    check_eq("bp_result", res, StdOut);
    send(0, {$urandom, $urandom, $urandom, $urandom}, '0, 0, res, exp, lat);
    check_eq("after_bp_result", res, exp);
    check_eq("after_bp_latency", 128'(lat), 128'd17);

`ifdef INV_LINEAR_KEYADD_EN
    send(0, StdIn, StdIn, 0, res, exp, lat);
    check_eq("key_cancel", res, 128'd0);
    send(2, StdIn, '0, 0, res, exp, lat);
    check_eq("key_zero", res, StdOut);
`endif

    // Randomized blocks on random instances
    for (int n = 0; n < 25; n++) begin
      u    = $urandom_range(0, NDut - 1);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      send(u, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           hold, res, exp, lat);
      check_eq("rand_result", res, exp);
      check_eq("rand_latency", 128'(lat), 128'(16 / (1 << u) + 1));
    end

    // Reset mid-BUSY: data_o currently holds a nonzero earlier result
    send(0, StdIn, '0, 0, res, exp, lat);
    @(negedge clk);
    vld[0] = 1'b1;
    din[0] = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);                 // accept
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_valid", 128'(vout[0]), 128'd0);
    check_eq("midrst_data", dout[0], 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_ready", 128'(rdy[0]), 128'd1);
    stale = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (vout[0]) stale = 1'b1;
    end
    check_eq("midrst_no_stale", 128'(stale), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
